xvec_stream_tx: RTL and testbench
=================================

Name: xvec_stream_tx

Overview:
Stream transmitter that feeds x-vectors into a convolution layer's s_*_x valid/ready input port. Software or a host block loads one LENX-word signed vector through a simple load port. On start, the block replays that vector num_frames times over a valid/ready master interface at one word per cycle. It is the producer end of the layer input protocol, used in system integration and as the bench driver.

Parameters:
WIDTH, 8, data word width (signed)
LENX, 3, words per vector/frame
ADDRX, 2, buffer address width, equal to $clog2(LENX), minimum 1
NFW, 8, width of num_frames

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ld_data  in  WIDTH  signed vector word to load
ld_valid  in  1  load word valid
ld_ready  out  1  load accepted when ld_valid && ld_ready
start  in  1  begin transmission (sampled in IDLE only)
num_frames  in  NFW  frames to send, latched at start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after last word handshake
loaded  out  1  complete vector present in buffer
m_data_out_x  out  WIDTH  signed stream data (RAM output register)
m_valid_x  out  1  stream valid
m_ready_x  in  1  stream ready from layer

Behaviour:
- Reset values: ld_ready=0 during reset; busy=0, done=0, loaded=0, m_valid_x=0. m_data_out_x is don't-care. Internal: wr_ptr=0, rd_ptr=0, frames_left=0, state=IDLE.
- States: IDLE, ARM, SEND, FIN.
- IDLE:
  - ld_ready = !start (combinational). Load has priority below start.
  - Each load handshake writes buffer[wr_ptr]. wr_ptr increments and wraps to 0 after LENX-1.
  - A write to address LENX-1 sets loaded=1.
  - A write to address 0 while loaded=1 clears loaded (new vector begun).
- Start acceptance: in IDLE with start=1, loaded=1 and num_frames!=0:
  - latch frames_left=num_frames, set rd_ptr=0, issue RAM read of address 0, go to ARM, busy=1.
  - If start arrives with loaded=0 or num_frames=0, it is ignored: no busy, no done, stay IDLE.
- ARM (1 cycle): RAM data for address 0 becomes available. Set m_valid_x=1, go to SEND. First m_valid_x therefore appears 2 cycles after the start cycle.
- SEND:
  - Read address each cycle = handshake ? next(rd_ptr) : rd_ptr. This holds m_data_out_x stable under backpressure and gives zero-bubble throughput with m_ready_x held high.
  - next(rd_ptr): rd_ptr+1, or 0 after LENX-1. Wrap decrements frames_left.
  - Handshake on the last word of the last frame (rd_ptr==LENX-1 and frames_left==1): m_valid_x=0 next cycle, go to FIN.
  - m_valid_x never deasserts mid-transfer without a handshake. No gap between frames.
- FIN (1 cycle): done=1, busy=0, go to IDLE. Buffer and loaded are retained, so a new start replays the same vector.
- ld_ready=0 in ARM, SEND and FIN. start is ignored outside IDLE.
- Reset mid-operation: immediate return to IDLE next edge with all outputs at reset values. loaded=0, so the buffer must be reloaded.
- Width rules: frames_left is NFW bits and decrements only on frame wrap. rd_ptr and wr_ptr compare against LENX-1, not 2^ADDRX-1, so a non-power-of-two LENX wraps correctly.

Decomposition:
- Package xvec_tx_pkg: state enum tx_state_t {IDLE, ARM, SEND, FIN}, and a function next_ptr(ptr, LENX) for wrap increment.
- One sub-module xvec_tx_buf: LENX x WIDTH single-address synchronous RAM with registered read, write enable, and a single address muxed from wr_ptr (IDLE) or the read address (other states). Reads and writes never overlap by construction.
- Control FSM, counters and load logic stay in the top.

Test Plan:
- Load [5,-2,7] (LENX=3), then start with num_frames=2 and m_ready_x=1: m_valid_x rises 2 cycles after start. Output is 5,-2,7,5,-2,7 on 6 consecutive cycles. done pulses one cycle after the final handshake. busy spans start+1 through the last word.
- Same load, num_frames=1, m_ready_x toggling 1,0,0,1,1: each word is held stable while m_ready_x=0. Sequence 5,-2,7 is delivered exactly once, with no duplicates or drops.
- start with loaded=0, or with num_frames=0: no busy, no m_valid_x, no done; ld_ready stays 1.
- After a completed run, write 9,9 only (partial reload): loaded=0 and start is ignored. Writing 4 next gives loaded=1, and a restart sends 9,9,4.
- Assert reset during the 2nd word of frame 1: next cycle m_valid_x=0, busy=0, loaded=0, ld_ready=1. A fresh load and start work normally.
- start and ld_valid asserted in the same cycle with loaded=1: ld_ready=0, so the write is not taken. Transmission starts with the old vector contents.

Source files
------------

// File: rtl/xvec_tx_pkg.sv
// Shared types and helpers for the x-vector stream transmitter.
package xvec_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } tx_state_t;

  // Wrap increment against the real vector length, not the address range.
  function automatic int next_ptr(input int ptr, input int lenx);
    return (ptr == lenx - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/xvec_tx_buf.sv
// Single-address vector buffer: synchronous write, registered read.
module xvec_tx_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter int AW    = 2
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           addr,
  input  logic signed [WIDTH-1:0] wdata,
  output logic signed [WIDTH-1:0] rdata
);

  logic signed [WIDTH-1:0] mem [DEPTH];

  // Writes only happen in IDLE, so read and write never collide.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    else    rdata     <= mem[addr];
  end

endmodule

// File: rtl/xvec_stream_tx.sv
// Replays a loaded LENX-word vector num_frames times on a valid/ready stream.
module xvec_stream_tx
  import xvec_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LENX  = 3,
  parameter int ADDRX = 2,
  parameter int NFW   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] ld_data,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic                    start,
  input  logic [NFW-1:0]          num_frames,
  output logic                    busy,
  output logic                    done,
  output logic                    loaded,
  output logic signed [WIDTH-1:0] m_data_out_x,
  output logic                    m_valid_x,
  input  logic                    m_ready_x
);

  localparam logic [ADDRX-1:0] LAST = ADDRX'(LENX - 1);

  tx_state_t        state, state_nxt;
  logic [ADDRX-1:0] wr_ptr, rd_ptr, rd_ptr_nxt, rd_addr, ram_addr;
  logic [ADDRX-1:0] wr_ptr_inc, rd_ptr_inc;
  logic [NFW-1:0]   frames_left, frames_nxt;
  logic             ld_fire, start_ok, hs, wrap, last_word;

  assign wr_ptr_inc = ADDRX'(next_ptr(int'(wr_ptr), LENX));
  assign rd_ptr_inc = ADDRX'(next_ptr(int'(rd_ptr), LENX));

  assign ld_ready  = (state == IDLE) && !start && !reset;
  assign ld_fire   = ld_valid && ld_ready;
  assign start_ok  = (state == IDLE) && start && loaded && (num_frames != '0);
  assign hs        = m_valid_x && m_ready_x;
  assign wrap      = hs && (rd_ptr == LAST);
  assign last_word = wrap && (frames_left == NFW'(1));

  assign busy      = (state == ARM) || (state == SEND);
  assign done      = (state == FIN);
  assign m_valid_x = (state == SEND);

  always_comb begin
    state_nxt  = state;
    rd_ptr_nxt = rd_ptr;
    frames_nxt = frames_left;
    rd_addr    = rd_ptr;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nxt  = ARM;
          rd_ptr_nxt = '0;
          frames_nxt = num_frames;
          rd_addr    = '0;
        end
      end
      ARM:  state_nxt = SEND;
      SEND: begin
        // Re-read the current word under backpressure so the output holds.
        if (hs) begin
          rd_ptr_nxt = rd_ptr_inc;
          rd_addr    = rd_ptr_inc;
          if (wrap)      frames_nxt = frames_left - NFW'(1);
          if (last_word) state_nxt  = FIN;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      frames_left <= '0;
      loaded      <= 1'b0;
    end else begin
      state       <= state_nxt;
      rd_ptr      <= rd_ptr_nxt;
      frames_left <= frames_nxt;
      if (ld_fire) begin
        wr_ptr <= wr_ptr_inc;
        if (wr_ptr == LAST)     loaded <= 1'b1;
        else if (wr_ptr == '0)  loaded <= 1'b0;
      end
    end
  end

  assign ram_addr = ld_fire ? wr_ptr : rd_addr;

  xvec_tx_buf #(
    .WIDTH (WIDTH),
    .DEPTH (LENX),
    .AW    (ADDRX)
  ) u_buf (
    .clk   (clk),
    .we    (ld_fire),
    .addr  (ram_addr),
    .wdata (ld_data),
    .rdata (m_data_out_x)
  );

endmodule

// File: tb/tb_xvec_stream_tx.sv
// Randomized scenario bench for xvec_stream_tx against a queue-based model.
module tb_xvec_stream_tx;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [7:0] ld_data;
  logic              ld_valid;
  logic              ld_ready;
  logic              start;
  logic [7:0]        num_frames;
  logic              busy, done, loaded;
  logic signed [7:0] m_data_out_x;
  logic              m_valid_x;
  logic              m_ready_x;

  xvec_stream_tx #(.WIDTH(8), .LENX(3), .ADDRX(2), .NFW(8)) dut (
    .clk(clk), .reset(reset), .ld_data(ld_data), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .start(start), .num_frames(num_frames),
    .busy(busy), .done(done), .loaded(loaded), .m_data_out_x(m_data_out_x),
    .m_valid_x(m_valid_x), .m_ready_x(m_ready_x)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic signed [7:0] vec [3];
  logic signed [7:0] got_q [$];
  logic signed [7:0] exp_q [$];
  logic [4:0]        pat;
  int first_lat, last_hs_k, done_k, done_cnt, hold_err, busy_err;
  logic coll_ready;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Reference stream: the vector repeated nf times.
  task automatic build_exp(input int nf);
    exp_q.delete();
    for (int f = 0; f < nf; f++)
      for (int i = 0; i < 3; i++) exp_q.push_back(vec[i]);
  endtask

  task automatic load_cur();
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = vec[i];
      @(negedge clk);
      total++;
      if (ld_ready !== 1'b1) begin
        bad++; $display("FAIL load_ready word=%0d got=%b exp=1", i, ld_ready);
      end
      cyc();
    end
    ld_valid = 1'b0;
  endtask

  task automatic check_seq(input string name);
    int mism;
    mism = 0;
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL %s_len got=%0d exp=%0d", name, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++)
        if (got_q[i] !== exp_q[i]) begin
          if (mism == 0)
            $display("FAIL %s_data idx=%0d got=%0d exp=%0d", name, i, got_q[i], exp_q[i]);
          mism++;
        end
      if (mism != 0) bad++;
    end
  endtask

  // Drives one start and records what the stream does; comparisons are in the tests.
  task automatic send_run(input int nf, input int rmode, input bit collide,
                          input logic signed [7:0] cdata);
    int  budget;
    bit  prev_stall;
    logic signed [7:0] prev_data;
    got_q.delete();
    first_lat = -1; last_hs_k = -1; done_k = -1;
    done_cnt = 0; hold_err = 0; busy_err = 0;
    prev_stall = 1'b0; prev_data = '0;
    num_frames = 8'(nf); start = 1'b1;
    if (collide) begin ld_valid = 1'b1; ld_data = cdata; end
    m_ready_x = 1'b1;
    @(negedge clk);
    coll_ready = ld_ready;
    cyc();
    start = 1'b0; ld_valid = 1'b0;
    budget = nf * 3 * 8 + 20;
    for (int k = 1; k <= budget && done_k < 0; k++) begin
      case (rmode)
        0:       m_ready_x = 1'b1;
        1:       m_ready_x = ($urandom % 4) != 0;
        default: m_ready_x = (k >= 2 && k - 2 < 5) ? pat[k-2] : 1'b1;
      endcase
      @(negedge clk);
      if (first_lat < 0 && m_valid_x) first_lat = k;
      if (prev_stall && (!m_valid_x || m_data_out_x !== prev_data)) hold_err++;
      if (busy !== !done) busy_err++;
      if (done) begin done_k = k; done_cnt++; end
      if (m_valid_x && m_ready_x) begin got_q.push_back(m_data_out_x); last_hs_k = k; end
      prev_stall = m_valid_x && !m_ready_x;
      prev_data  = m_data_out_x;
      cyc();
    end
    total++;
    if (done_k < 0) begin
      bad++; $display("FAIL run_timeout got=no_done exp=done within %0d cycles", budget);
    end else begin
      @(negedge clk);
      if (done) done_cnt++;
      if (busy || m_valid_x) busy_err++;
      cyc();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ld_valid = 1'b0; ld_data = '0; start = 1'b0;
    num_frames = '0; m_ready_x = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    total++;
    if ({ld_ready, busy, done, loaded, m_valid_x} !== 5'b0) begin
      bad++; $display("FAIL reset_outs got=%b exp=00000", {ld_ready, busy, done, loaded, m_valid_x});
    end
    cyc();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (ld_ready !== 1'b1) begin bad++; $display("FAIL reset_ldready got=%b exp=1", ld_ready); end
    cyc();
  endtask

  task automatic test_ignored_start(input int nf, input string name);
    int seen;
    seen = 0;
    num_frames = 8'(nf); start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (busy || m_valid_x || done || !ld_ready) seen++;
      cyc();
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL %s got=%0d_active_cycles exp=0", name, seen); end
  endtask

  task automatic test_basic();
    vec[0] = 8'sd5; vec[1] = -8'sd2; vec[2] = 8'sd7;
    load_cur();
    @(negedge clk);
    total++;
    if (loaded !== 1'b1) begin bad++; $display("FAIL basic_loaded got=%b exp=1", loaded); end
    cyc();
    test_ignored_start(0, "start_nf0_ignored");
    build_exp(2);
    send_run(2, 0, 1'b0, '0);
    check_seq("basic_seq");
    total++;
    if (first_lat != 2) begin bad++; $display("FAIL basic_latency got=%0d exp=2", first_lat); end
    total++;
    if (last_hs_k - first_lat + 1 != 6) begin
      bad++; $display("FAIL basic_contig got=%0d exp=6", last_hs_k - first_lat + 1);
    end
    total++;
    if (done_k != last_hs_k + 1 || done_cnt != 1) begin
      bad++; $display("FAIL basic_done got=k%0d/cnt%0d exp=k%0d/cnt1", done_k, done_cnt, last_hs_k + 1);
    end
    total++;
    if (busy_err != 0) begin bad++; $display("FAIL basic_busy got=%0d exp=0", busy_err); end
  endtask

  task automatic test_backpressure();
    build_exp(1);
    send_run(1, 2, 1'b0, '0);
    check_seq("bp_seq");
    total++;
    if (hold_err != 0) begin bad++; $display("FAIL bp_hold got=%0d exp=0", hold_err); end
    total++;
    if (done_k != last_hs_k + 1 || done_cnt != 1) begin
      bad++; $display("FAIL bp_done got=k%0d/cnt%0d exp=k%0d/cnt1", done_k, done_cnt, last_hs_k + 1);
    end
  endtask

  task automatic test_partial_reload();
    ld_valid = 1'b1; ld_data = 8'sd9; cyc(); cyc();
    ld_valid = 1'b0;
    @(negedge clk);
    total++;
    if (loaded !== 1'b0) begin bad++; $display("FAIL partial_loaded got=%b exp=0", loaded); end
    cyc();
    test_ignored_start(1, "partial_start_ignored");
    ld_valid = 1'b1; ld_data = 8'sd4; cyc();
    ld_valid = 1'b0;
    @(negedge clk);
    total++;
    if (loaded !== 1'b1) begin bad++; $display("FAIL partial_reloaded got=%b exp=1", loaded); end
    cyc();
    vec[0] = 8'sd9; vec[1] = 8'sd9; vec[2] = 8'sd4;
    build_exp(1);
    send_run(1, 0, 1'b0, '0);
    check_seq("partial_seq");
  endtask

  task automatic test_collision();
    build_exp(1);
    send_run(1, 0, 1'b1, -8'sd100);
    total++;
    if (coll_ready !== 1'b0) begin bad++; $display("FAIL coll_ldready got=%b exp=0", coll_ready); end
    check_seq("coll_seq");
  endtask

  task automatic test_reset_mid();
    m_ready_x = 1'b1; num_frames = 8'd2; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc();                  // ARM, then word 0
    @(negedge clk);
    total++;
    if (!m_valid_x || m_data_out_x !== vec[1]) begin
      bad++; $display("FAIL mid_word1 got=%b/%0d exp=1/%0d", m_valid_x, m_data_out_x, vec[1]);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({m_valid_x, busy, loaded, ld_ready} !== 4'b0001) begin
      bad++; $display("FAIL mid_reset got=%b exp=0001", {m_valid_x, busy, loaded, ld_ready});
    end
    cyc();
    vec[0] = -8'sd128; vec[1] = 8'sd127; vec[2] = 8'sd0;
    load_cur();
    build_exp(2);
    send_run(2, 0, 1'b0, '0);
    check_seq("mid_fresh_seq");
  endtask

  task automatic test_random();
    int nf;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 3; i++) vec[i] = 8'($urandom);
      nf = $urandom_range(1, 4);
      load_cur();
      build_exp(nf);
      send_run(nf, 1, 1'b0, '0);
      check_seq("rand_seq");
      total++;
      if (hold_err != 0 || busy_err != 0 || done_cnt != 1 || done_k != last_hs_k + 1) begin
        bad++;
        $display("FAIL rand_ctrl it=%0d got=hold%0d/busy%0d/done%0d exp=0/0/1", it, hold_err, busy_err, done_cnt);
      end
    end
  endtask

  initial begin
    pat = 5'b11001;
    test_reset();
    test_ignored_start(2, "start_unloaded_ignored");
    test_basic();
    test_backpressure();
    test_partial_reload();
    test_collision();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
